// File: rtl/play_timer.sv
// Whole-second game clock: loads PLAY_SEC, counts down in BCD while the game FSM is in PLAY,
// flags gameover at 00. Optional pause input is enabled by defining TIMER_PAUSE_EN.
module play_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int PLAY_SEC  = 60,
  parameter int BONUS_SEC = 5,
  parameter int WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] state_i,
  input  logic       bonus_add_i,
`ifdef TIMER_PAUSE_EN
  input  logic       pause_i,
`endif
  output logic       gameover_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       tick_o,
  output logic       warn_o,
  output logic       warn_blink_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CTWN = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;

  localparam int PW = ($clog2(CLK_HZ) > 0) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TERM   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF   = PW'(CLK_HZ / 2);
  localparam logic [3:0]    PLAY_T = 4'(PLAY_SEC / 10);
  localparam logic [3:0]    PLAY_O = 4'(PLAY_SEC % 10);
  localparam logic [7:0]    BONUS_B = 8'(BONUS_SEC);
  localparam logic [6:0]    WARN_B  = 7'(WARN_SEC);

  if (CLK_HZ < 2 || PLAY_SEC < 1 || PLAY_SEC > 99 || BONUS_SEC < 0 || BONUS_SEC > 99 ||
      WARN_SEC < 0 || WARN_SEC > 99) begin : g_param_err
    $error("play_timer: parameter out of range");
  end

  typedef enum logic [1:0] {T_LOAD, T_RUN, T_DONE} tstate_e;

  tstate_e       fsm_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    tens_q, ones_q;
  logic          go_q, tick_q;

  logic          run_en;
  logic          load_req, time_zero, wrap, advance;
  logic [6:0]    bin;
  logic [7:0]    sum_raw;
  logic [6:0]    sum_sat;
  logic [3:0]    tens_d, ones_d;

`ifdef TIMER_PAUSE_EN
  assign run_en = ~pause_i;
`else
  assign run_en = 1'b1;
`endif

  assign load_req  = (state_i == ST_IDLE) || (state_i == ST_CTWN);
  assign time_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign wrap      = (presc_q == TERM);
  assign advance   = (fsm_q == T_RUN) && (state_i == ST_PLAY) && !time_zero && run_en;

  // Tick decrement and bonus are folded into one binary add so they combine in a single cycle.
  always_comb begin
    bin     = ({3'b000, tens_q} * 7'd10) + {3'b000, ones_q};
    sum_raw = {1'b0, bin} - {7'd0, wrap} + (bonus_add_i ? BONUS_B : 8'd0);
    sum_sat = (sum_raw > 8'd99) ? 7'd99 : sum_raw[6:0];
    tens_d  = 4'(sum_sat / 7'd10);
    ones_d  = 4'(sum_sat % 7'd10);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= T_LOAD;
      presc_q <= '0;
      tens_q  <= PLAY_T;
      ones_q  <= PLAY_O;
      go_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (load_req) begin
        fsm_q   <= T_LOAD;
        presc_q <= '0;
        tens_q  <= PLAY_T;
        ones_q  <= PLAY_O;
        go_q    <= 1'b0;
      end else begin
        case (fsm_q)
          T_LOAD: if (state_i == ST_PLAY) fsm_q <= T_RUN;
          T_RUN: begin
            if (time_zero) begin
              fsm_q <= T_DONE;
              go_q  <= 1'b1;
            end else if (advance) begin
              presc_q <= wrap ? '0 : presc_q + 1'b1;
              tick_q  <= wrap;
              tens_q  <= tens_d;
              ones_q  <= ones_d;
            end
          end
          T_DONE:  go_q  <= 1'b1;
          default: fsm_q <= T_LOAD;
        endcase
      end
    end
  end

  assign gameover_o   = go_q;
  assign sec_tens_o   = tens_q;
  assign sec_ones_o   = ones_q;
  assign tick_o       = tick_q;
  assign warn_o       = (state_i == ST_PLAY) && !time_zero && (bin <= WARN_B);
  assign warn_blink_o = warn_o && (presc_q < HALF);

endmodule

// File: tb/tb_play_timer.sv
// Bench for play_timer: directed vector table, hand sequences for reset/saturation/pause,
// and a randomized run against an integer-seconds reference model.
module tb_play_timer;
  localparam int CLK_HZ = 10, PLAY_SEC = 3, BONUS_SEC = 5, WARN_SEC = 2;
  localparam logic [1:0] IDLE = 2'd0, CTWN = 2'd1, PLAY = 2'd2, ENDS = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] state;
  logic       bonus;
`ifdef TIMER_PAUSE_EN
  logic       pause;
`endif
  logic       go, tick, warn, blink;
  logic [3:0] tens, ones;

  logic [1:0] state2;
  logic       bonus2;
  logic       go2, tick2, warn2, blink2;
  logic [3:0] tens2, ones2;

  play_timer #(.CLK_HZ(CLK_HZ), .PLAY_SEC(PLAY_SEC), .BONUS_SEC(BONUS_SEC), .WARN_SEC(WARN_SEC)) dut (
    .clk(clk), .rst_n(rst_n), .state_i(state), .bonus_add_i(bonus),
`ifdef TIMER_PAUSE_EN
    .pause_i(pause),
`endif
    .gameover_o(go), .sec_tens_o(tens), .sec_ones_o(ones), .tick_o(tick),
    .warn_o(warn), .warn_blink_o(blink));

  play_timer #(.CLK_HZ(CLK_HZ), .PLAY_SEC(99), .BONUS_SEC(BONUS_SEC), .WARN_SEC(WARN_SEC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .state_i(state2), .bonus_add_i(bonus2),
`ifdef TIMER_PAUSE_EN
    .pause_i(1'b0),
`endif
    .gameover_o(go2), .sec_tens_o(tens2), .sec_ones_o(ones2), .tick_o(tick2),
    .warn_o(warn2), .warn_blink_o(blink2));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: whole seconds remaining plus cycles elapsed in the current second.
  int m_mode;  // 0 loaded/waiting, 1 counting, 2 finished
  int m_time, m_cnt;
  bit m_go, m_tick;

  function automatic void model_reset();
    m_mode = 0; m_time = PLAY_SEC; m_cnt = 0; m_go = 0; m_tick = 0;
  endfunction

  function automatic void model_step();
    bit paused;
    int t;
    paused = 1'b0;
`ifdef TIMER_PAUSE_EN
    paused = pause;
`endif
    m_tick = 0;
    if (state == IDLE || state == CTWN) begin
      m_mode = 0; m_time = PLAY_SEC; m_cnt = 0; m_go = 0;
    end else if (m_mode == 0) begin
      if (state == PLAY) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_time == 0) begin
        m_mode = 2; m_go = 1;
      end else if (state == PLAY && !paused) begin
        t = m_time;
        if (m_cnt == CLK_HZ - 1) begin m_cnt = 0; m_tick = 1; t = t - 1; end
        else m_cnt = m_cnt + 1;
        if (bonus) t = t + BONUS_SEC;
        m_time = (t > 99) ? 99 : t;
      end
    end
  endfunction

  task automatic step_clk();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] st; logic bon; int n;
    int tens; int ones; int go; int tk; int w; int b;
  } vec_t;
  vec_t tbl[21];

  initial begin
    tbl[0]  = '{IDLE, 1'b0, 1,  0, 3, 0, 0, 0, 0};
    tbl[1]  = '{CTWN, 1'b0, 1,  0, 3, 0, 0, 0, 0};
    tbl[2]  = '{PLAY, 1'b0, 1,  0, 3, 0, 0, 0, 0};
    tbl[3]  = '{PLAY, 1'b0, 9,  0, 3, 0, 0, 0, 0};
    tbl[4]  = '{PLAY, 1'b0, 1,  0, 2, 0, 1, 1, 1};
    tbl[5]  = '{PLAY, 1'b0, 1,  0, 2, 0, 0, 1, 1};
    tbl[6]  = '{PLAY, 1'b0, 9,  0, 1, 0, 1, 1, 1};
    tbl[7]  = '{PLAY, 1'b0, 7,  0, 1, 0, 0, 1, 0};
    tbl[8]  = '{PLAY, 1'b0, 3,  0, 0, 0, 1, 0, 0};
    tbl[9]  = '{PLAY, 1'b0, 1,  0, 0, 1, 0, 0, 0};
    tbl[10] = '{PLAY, 1'b1, 1,  0, 0, 1, 0, 0, 0};
    tbl[11] = '{ENDS, 1'b0, 3,  0, 0, 1, 0, 0, 0};
    tbl[12] = '{IDLE, 1'b0, 1,  0, 3, 0, 0, 0, 0};
    tbl[13] = '{CTWN, 1'b1, 1,  0, 3, 0, 0, 0, 0};
    tbl[14] = '{PLAY, 1'b0, 1,  0, 3, 0, 0, 0, 0};
    tbl[15] = '{PLAY, 1'b0, 29, 0, 1, 0, 0, 1, 0};
    tbl[16] = '{PLAY, 1'b1, 1,  0, 5, 0, 1, 0, 0};
    tbl[17] = '{PLAY, 1'b0, 10, 0, 4, 0, 1, 0, 0};
    tbl[18] = '{PLAY, 1'b1, 1,  0, 9, 0, 0, 0, 0};
    tbl[19] = '{ENDS, 1'b1, 2,  0, 9, 0, 0, 0, 0};
    tbl[20] = '{IDLE, 1'b0, 1,  0, 3, 0, 0, 0, 0};

    rst_n = 1'b0; state = IDLE; bonus = 1'b0; state2 = IDLE; bonus2 = 1'b0;
`ifdef TIMER_PAUSE_EN
    pause = 1'b0;
`endif
    model_reset();
    #12;
    chk("reset tens", tens, 0);
    chk("reset ones", ones, 3);
    chk("reset gameover", go, 0);
    chk("reset tick", tick, 0);
    chk("reset warn", warn, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      state = tbl[i].st;
      bonus = tbl[i].bon;
      for (int k = 0; k < tbl[i].n; k++) begin
        step_clk();
        bonus = 1'b0;
      end
      chk($sformatf("vec%0d tens", i), tens, tbl[i].tens);
      chk($sformatf("vec%0d ones", i), ones, tbl[i].ones);
      chk($sformatf("vec%0d gameover", i), go, tbl[i].go);
      chk($sformatf("vec%0d tick", i), tick, tbl[i].tk);
      chk($sformatf("vec%0d warn", i), warn, tbl[i].w);
      chk($sformatf("vec%0d warn_blink", i), blink, tbl[i].b);
    end

    // Asynchronous reset landing on the cycle that carries a tick.
    state = CTWN; step_clk();
    state = PLAY; step_clk();
    for (int k = 0; k < 10; k++) step_clk();
    chk("pre-reset tick", tick, 1);
    chk("pre-reset ones", ones, 2);
    rst_n = 1'b0;
    #1;
    chk("async reset tick", tick, 0);
    chk("async reset ones", ones, 3);
    chk("async reset gameover", go, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; state = IDLE;
    model_reset();
    step_clk();

    // Saturation at 99 on the PLAY_SEC=99 instance.
    state2 = CTWN; @(posedge clk); #1;
    state2 = PLAY; @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; end
    chk("sat pre tens", tens2, 9);
    chk("sat pre ones", ones2, 8);
    bonus2 = 1'b1; @(posedge clk); #1; bonus2 = 1'b0;
    chk("sat 98+5 tens", tens2, 9);
    chk("sat 98+5 ones", ones2, 9);
    bonus2 = 1'b1; @(posedge clk); #1; bonus2 = 1'b0;
    chk("sat 99+5 ones", ones2, 9);
    state2 = IDLE;

`ifdef TIMER_PAUSE_EN
    begin
      int seen_tick;
      state = CTWN; step_clk();
      state = PLAY; step_clk();
      for (int k = 0; k < 4; k++) step_clk();
      pause = 1'b1;
      seen_tick = 0;
      for (int k = 0; k < 25; k++) begin
        step_clk();
        if (tick) seen_tick++;
      end
      chk("pause ticks", seen_tick, 0);
      chk("pause ones", ones, 3);
      pause = 1'b0;
      for (int k = 0; k < 5; k++) step_clk();
      chk("resume early tick", tick, 0);
      chk("resume early ones", ones, 3);
      step_clk();
      chk("resume tick", tick, 1);
      chk("resume ones", ones, 2);
      state = IDLE; step_clk();
    end
`endif

    // Randomized run against the reference model.
    rst_n = 1'b0; state = IDLE; bonus = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int r;
      int exp_t, exp_o, exp_w, exp_b;
      r = $urandom_range(99);
      state = (r < 3) ? IDLE : (r < 5) ? CTWN : (r < 10) ? ENDS : PLAY;
      bonus = ($urandom_range(9) == 0);
`ifdef TIMER_PAUSE_EN
      pause = ($urandom_range(4) == 0);
`endif
      step_clk();
      exp_t = m_time / 10;
      exp_o = m_time % 10;
      exp_w = (state == PLAY && m_time != 0 && m_time <= WARN_SEC) ? 1 : 0;
      exp_b = (exp_w == 1 && m_cnt < CLK_HZ / 2) ? 1 : 0;
      chk($sformatf("rand c%0d {tens,ones,go,tick,warn,blink}", c),
          {tens, ones, go, tick, warn, blink},
          {exp_t[3:0], exp_o[3:0], m_go, m_tick, exp_w[0], exp_b[0]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
